// File: rtl/mem_bus_pkg.sv
// Shared types for the C2 line-bus arbiter: bus command encodings and the
// arbiter FSM state set.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_RESPONSE   = 2'd1,
    C2_READ_LINE  = 2'd2,
    C2_WRITE_LINE = 2'd3
  } c2_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_CMD    = 3'd1,
    ST_WR_DATA   = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_RD_DATA   = 3'd4,
    ST_DONE      = 3'd5
  } arb_state_e;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_LINE_BEATS = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side bundle of the arbiter: per-requester line requests in,
// grant/done/err and the assembled read line out.
interface mem_bus_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int LINE_BEATS = 8
);
  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0]                   req_write;
  logic [NUM_REQ*ADDR_W-1:0]            req_addr;
  logic [NUM_REQ*LINE_BEATS*DATA_W-1:0] req_wline;
  logic [NUM_REQ-1:0]                   grant;
  logic [NUM_REQ-1:0]                   done;
  logic                                 err;
  logic [LINE_BEATS*DATA_W-1:0]         rline;

  modport master (
    output req_valid, req_write, req_addr, req_wline,
    input  grant, done, err, rline
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wline,
    output grant, done, err, rline
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    j        = 0;
    onehot_o = {N{1'b0}};
    idx_o    = {PW{1'b0}};
    any_o    = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[j]) begin
        onehot_o[j] = 1'b1;
        idx_o       = PW'(j);
        any_o       = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serializing whole-line read/write requests onto the
// DATA_W-wide C2 bus and reassembling read beats into a line.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_BEATS = DEF_LINE_BEATS,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  req_if,
  output logic [1:0]        mem_cmd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [1:0]        mem_cmd_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(LINE_BEATS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = LINE_BEATS * DATA_W;

  arb_state_e          state_q;
  c2_cmd_e             mem_cmd_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                err_q;
  logic [LW-1:0]       rline_q;
  logic [LW-1:0]       wline_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [PW-1:0]       rr_ptr_q;
  logic [PW-1:0]       winner_q;
  logic                write_q;
  logic [BW-1:0]       beat_cnt_q;
  logic [TW-1:0]       timer_q;

  logic [NUM_REQ-1:0]  pick_oh_s;
  logic [PW-1:0]       pick_idx_s;
  logic                pick_any_s;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_rr_pick (
    .req_i    (req_if.req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh_s),
    .idx_o    (pick_idx_s),
    .any_o    (pick_any_s)
  );

  // Single-process FSM; every visible output is a register written here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_cmd_q   <= C2_NOP;
      grant_q     <= {NUM_REQ{1'b0}};
      done_q      <= {NUM_REQ{1'b0}};
      err_q       <= 1'b0;
      rline_q     <= {LW{1'b0}};
      wline_q     <= {LW{1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rr_ptr_q    <= {PW{1'b0}};
      winner_q    <= {PW{1'b0}};
      write_q     <= 1'b0;
      beat_cnt_q  <= {BW{1'b0}};
      timer_q     <= {TW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any_s) begin
            grant_q    <= pick_oh_s;
            winner_q   <= pick_idx_s;
            write_q    <= req_if.req_write[pick_idx_s];
            mem_addr_q <= req_if.req_addr[pick_idx_s*ADDR_W +: ADDR_W];
            wline_q    <= req_if.req_wline[pick_idx_s*LW +: LW];
            timer_q    <= {TW{1'b0}};
            if (req_if.req_write[pick_idx_s]) begin
              mem_cmd_q   <= C2_WRITE_LINE;
              mem_wdata_q <= req_if.req_wline[pick_idx_s*LW +: DATA_W];
              beat_cnt_q  <= BW'(1);
              state_q     <= ST_WR_DATA;
            end else begin
              mem_cmd_q <= C2_READ_LINE;
              state_q   <= ST_RD_CMD;
            end
          end
        end
        ST_WR_DATA: begin
          // beat_cnt_q counts beats already on the bus, beat 0 went out from IDLE
          if (beat_cnt_q == BW'(LINE_BEATS)) begin
            mem_cmd_q  <= C2_NOP;
            beat_cnt_q <= {BW{1'b0}};
            state_q    <= ST_WAIT_RESP;
          end else begin
            mem_wdata_q <= wline_q[beat_cnt_q*DATA_W +: DATA_W];
            beat_cnt_q  <= beat_cnt_q + 1'b1;
          end
        end
        ST_RD_CMD: begin
          mem_cmd_q <= C2_NOP;
          state_q   <= ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          if (mem_cmd_i == C2_RESPONSE) begin
            if (write_q) begin
              done_q  <= grant_q;
              err_q   <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              rline_q[DATA_W-1:0] <= mem_rdata_i;
              beat_cnt_q          <= BW'(1);
              state_q             <= ST_RD_DATA;
            end
          end else if (timer_q == TW'(TIMEOUT)) begin
            done_q  <= grant_q;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_RD_DATA: begin
          rline_q[beat_cnt_q*DATA_W +: DATA_W] <= mem_rdata_i;
          if (beat_cnt_q == BW'(LINE_BEATS - 1)) begin
            done_q     <= grant_q;
            err_q      <= 1'b0;
            beat_cnt_q <= {BW{1'b0}};
            state_q    <= ST_DONE;
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          done_q   <= {NUM_REQ{1'b0}};
          err_q    <= 1'b0;
          grant_q  <= {NUM_REQ{1'b0}};
          rr_ptr_q <= (winner_q == PW'(NUM_REQ - 1)) ? {PW{1'b0}} : winner_q + 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          mem_cmd_q <= C2_NOP;
          grant_q   <= {NUM_REQ{1'b0}};
          done_q    <= {NUM_REQ{1'b0}};
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_if.grant = grant_q;
  assign req_if.done  = done_q;
  assign req_if.err   = err_q;
  assign req_if.rline = rline_q;
  assign mem_cmd_o    = mem_cmd_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
